rect_fill_writer: RTL and testbench

Command-driven pixel writer that fills an axis-aligned rectangle with one 8-bit colour by emitting one pixel write per accepted cycle on the framebuffer write port (PIX_HORIZONTAL / PIX_VERTICAL / PIX_COLOR). It is the initiator for the framebuffer's write side. It sits between the drawing/control logic and the framebuffer, in the PIXEL_CLK domain.

---
 rtl/fb_pkg.sv | 17 +
 rtl/rect_fill_writer.sv | 167 ++++++++++++++++
 tb/tb_rect_fill_writer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer-side types and constants.
// State encoding, coordinate/colour widths, default screen size.
package fb_pkg;

  localparam int CW        = 10;
  localparam int COLW      = 8;
  localparam int HSIZE_DEF = 800;
  localparam int VSIZE_DEF = 600;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_FILL  = 2'd2,
    S_DONE  = 2'd3
  } fill_state_e;

endpackage

// File: rtl/rect_fill_writer.sv
// Rectangle fill pixel writer: one write per accepted cycle, raster order.
// Optional clipping to the visible area with RECT_FILL_CLIP_EN.
module rect_fill_writer
  import fb_pkg::*;
`ifdef RECT_FILL_CLIP_EN
#(
  parameter int HSIZE = HSIZE_DEF,
  parameter int VSIZE = VSIZE_DEF
)
`endif
(
  input  logic            PIXEL_CLK,
  input  logic            RST,
  input  logic            CMD_VALID,
  output logic            CMD_READY,
  input  logic [CW-1:0]   CMD_X0,
  input  logic [CW-1:0]   CMD_Y0,
  input  logic [CW-1:0]   CMD_X1,
  input  logic [CW-1:0]   CMD_Y1,
  input  logic [COLW-1:0] CMD_COLOR,
  output logic [CW-1:0]   PIX_HORIZONTAL,
  output logic [CW-1:0]   PIX_VERTICAL,
  output logic [COLW-1:0] PIX_COLOR,
  output logic            PIX_WE,
  input  logic            PIX_READY,
  output logic            BUSY,
  output logic            DONE
);

  fill_state_e     state_q, state_d;
  logic [CW-1:0]   x0_q, x0_d;
  logic [CW-1:0]   y0_q, y0_d;
  logic [CW-1:0]   x1_q, x1_d;
  logic [CW-1:0]   y1_q, y1_d;
  logic [COLW-1:0] col_q, col_d;
  logic [CW-1:0]   xmin_q, xmin_d;
  logic [CW-1:0]   xmax_q, xmax_d;
  logic [CW-1:0]   ymax_q, ymax_d;
  logic [CW-1:0]   x_q, x_d;
  logic [CW-1:0]   y_q, y_d;

  logic [CW-1:0]   nxmin, nxmax;
  logic [CW-1:0]   nymin, nymax;
  logic [CW-1:0]   cxmax, cymax;
  logic            empty;

  // Normalise the latched corners, then optionally clip to the screen.
  always_comb begin
    nxmin = (x0_q > x1_q) ? x1_q : x0_q;
    nxmax = (x0_q > x1_q) ? x0_q : x1_q;
    nymin = (y0_q > y1_q) ? y1_q : y0_q;
    nymax = (y0_q > y1_q) ? y0_q : y1_q;
    cxmax = nxmax;
    cymax = nymax;
    empty = 1'b0;
`ifdef RECT_FILL_CLIP_EN
    if ({1'b0, nxmin} >= (CW+1)'(HSIZE) ||
        {1'b0, nymin} >= (CW+1)'(VSIZE)) begin
      empty = 1'b1;
    end
    if ({1'b0, nxmax} > (CW+1)'(HSIZE - 1)) begin
      cxmax = CW'(HSIZE - 1);
    end
    if ({1'b0, nymax} > (CW+1)'(VSIZE - 1)) begin
      cymax = CW'(VSIZE - 1);
    end
`endif
  end

  // Next-state logic: accept, set up, raster walk, completion.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    col_d   = col_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymax_d  = ymax_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          x0_d    = CMD_X0;
          y0_d    = CMD_Y0;
          x1_d    = CMD_X1;
          y1_d    = CMD_Y1;
          col_d   = CMD_COLOR;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (empty) begin
          state_d = S_DONE;
        end else begin
          xmin_d  = nxmin;
          xmax_d  = cxmax;
          ymax_d  = cymax;
          x_d     = nxmin;
          y_d     = nymin;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (PIX_READY) begin
          if (x_q < xmax_q) begin
            x_d = x_q + 1'b1;
          end else if (y_q < ymax_q) begin
            x_d = xmin_q;
            y_d = y_q + 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any fill in progress.
  always_ff @(posedge PIXEL_CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      col_q   <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymax_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      col_q   <= col_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymax_q  <= ymax_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Outputs come straight from registers; PIX_WE depends on state only.
  always_comb begin
    CMD_READY      = (state_q == S_IDLE);
    PIX_WE         = (state_q == S_FILL);
    BUSY           = (state_q != S_IDLE);
    DONE           = (state_q == S_DONE);
    PIX_HORIZONTAL = x_q;
    PIX_VERTICAL   = y_q;
    PIX_COLOR      = col_q;
  end

endmodule

// File: tb/tb_rect_fill_writer.sv
// Directed self-checking bench for rect_fill_writer.
// Clip cases compile in when RECT_FILL_CLIP_EN is defined.
module tb_rect_fill_writer;

  logic       PIXEL_CLK;
  logic       RST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [9:0] CMD_X0, CMD_Y0, CMD_X1, CMD_Y1;
  logic [7:0] CMD_COLOR;
  logic [9:0] PIX_HORIZONTAL, PIX_VERTICAL;
  logic [7:0] PIX_COLOR;
  logic       PIX_WE;
  logic       PIX_READY;
  logic       BUSY;
  logic       DONE;

  int passed;
  int total;

  logic       we_l [64];
  logic       dn_l [64];
  logic       rd_l [64];
  logic [9:0] xl   [64];
  logic [9:0] yl   [64];
  logic [7:0] cl   [64];
  logic [9:0] wx   [64];
  logic [9:0] wy   [64];
  logic [7:0] wc   [64];
  int         wcyc [64];
  int         nwr;
  int         done_c;

  rect_fill_writer dut (
    .PIXEL_CLK      (PIXEL_CLK),
    .RST            (RST),
    .CMD_VALID      (CMD_VALID),
    .CMD_READY      (CMD_READY),
    .CMD_X0         (CMD_X0),
    .CMD_Y0         (CMD_Y0),
    .CMD_X1         (CMD_X1),
    .CMD_Y1         (CMD_Y1),
    .CMD_COLOR      (CMD_COLOR),
    .PIX_HORIZONTAL (PIX_HORIZONTAL),
    .PIX_VERTICAL   (PIX_VERTICAL),
    .PIX_COLOR      (PIX_COLOR),
    .PIX_WE         (PIX_WE),
    .PIX_READY      (PIX_READY),
    .BUSY           (BUSY),
    .DONE           (DONE)
  );

  initial PIXEL_CLK = 1'b0;
  always #5 PIXEL_CLK = ~PIXEL_CLK;

  // Issue one command, then log cycles 1.. until the cycle after DONE.
  // PIX_READY is low in cycles [st_from, st_from+st_len).
  task automatic run_cmd(input logic [9:0] x0, input logic [9:0] y0,
                         input logic [9:0] x1, input logic [9:0] y1,
                         input logic [7:0] col,
                         input int st_from, input int st_len);
    @(negedge PIXEL_CLK);
    CMD_X0 = x0; CMD_Y0 = y0;
    CMD_X1 = x1; CMD_Y1 = y1;
    CMD_COLOR = col;
    CMD_VALID = 1'b1;
    @(posedge PIXEL_CLK);
    #1;
    CMD_VALID = 1'b0;
    nwr = 0;
    done_c = -1;
    for (int i = 0; i < 64; i++) begin
      we_l[i] = 1'b0; dn_l[i] = 1'b0; rd_l[i] = 1'b0;
      xl[i] = '0; yl[i] = '0; cl[i] = '0;
    end
    for (int c = 1; c < 64; c++) begin
      if (c > 1) begin
        @(posedge PIXEL_CLK);
        #1;
      end
      PIX_READY = !(c >= st_from && c < st_from + st_len);
      we_l[c] = PIX_WE;
      dn_l[c] = DONE;
      rd_l[c] = CMD_READY;
      xl[c]   = PIX_HORIZONTAL;
      yl[c]   = PIX_VERTICAL;
      cl[c]   = PIX_COLOR;
      if (PIX_WE && PIX_READY) begin
        wx[nwr] = PIX_HORIZONTAL;
        wy[nwr] = PIX_VERTICAL;
        wc[nwr] = PIX_COLOR;
        wcyc[nwr] = c;
        nwr++;
      end
      if (DONE && done_c < 0) done_c = c;
      if (done_c >= 0 && c == done_c + 1) break;
    end
    PIX_READY = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge PIXEL_CLK);
    @(negedge PIXEL_CLK);
    RST = 1'b0;
    #1;
    total++;
    if (PIX_WE !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0)
      $display("FAIL reset_ctl: we=%b busy=%b done=%b want 0 0 0",
               PIX_WE, BUSY, DONE);
    else passed++;
    total++;
    if (CMD_READY !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", CMD_READY);
    else passed++;
    total++;
    if (PIX_HORIZONTAL !== 10'd0 || PIX_VERTICAL !== 10'd0 ||
        PIX_COLOR !== 8'd0)
      $display("FAIL reset_pix: x=%0d y=%0d c=%h want 0 0 00",
               PIX_HORIZONTAL, PIX_VERTICAL, PIX_COLOR);
    else passed++;
  endtask

  task automatic test_single_pixel();
    run_cmd(10'd5, 10'd7, 10'd5, 10'd7, 8'hA5, 0, 0);
    total++;
    if (rd_l[1] !== 1'b0)
      $display("FAIL single_ready_c1: got %b want 0", rd_l[1]);
    else passed++;
    total++;
    if (nwr !== 1)
      $display("FAIL single_count: got %0d want 1", nwr);
    else passed++;
    total++;
    if (wx[0] !== 10'd5 || wy[0] !== 10'd7 || wc[0] !== 8'hA5 ||
        wcyc[0] !== 2)
      $display("FAIL single_write: got (%0d,%0d,%h)@%0d want (5,7,a5)@2",
               wx[0], wy[0], wc[0], wcyc[0]);
    else passed++;
    total++;
    if (done_c !== 3)
      $display("FAIL single_done: got cycle %0d want 3", done_c);
    else passed++;
    total++;
    if (rd_l[4] !== 1'b1)
      $display("FAIL single_ready_c4: got %b want 1", rd_l[4]);
    else passed++;
  endtask

  task automatic test_swapped();
    logic [9:0] ex [6];
    logic [9:0] ey [6];
    int bad;
    ex = '{10'd10, 10'd11, 10'd12, 10'd10, 10'd11, 10'd12};
    ey = '{10'd3, 10'd3, 10'd3, 10'd4, 10'd4, 10'd4};
    run_cmd(10'd12, 10'd4, 10'd10, 10'd3, 8'h5A, 0, 0);
    total++;
    if (nwr !== 6)
      $display("FAIL swap_count: got %0d want 6", nwr);
    else passed++;
    bad = -1;
    for (int i = 0; i < 6; i++)
      if (bad < 0 && (wx[i] !== ex[i] || wy[i] !== ey[i] ||
                      wcyc[i] !== i + 2))
        bad = i;
    total++;
    if (bad >= 0)
      $display("FAIL swap_order: write %0d got (%0d,%0d)@%0d want (%0d,%0d)@%0d",
               bad, wx[bad], wy[bad], wcyc[bad], ex[bad], ey[bad], bad + 2);
    else passed++;
    total++;
    if (done_c !== 8)
      $display("FAIL swap_done: got cycle %0d want 8", done_c);
    else passed++;
  endtask

  task automatic test_backpressure();
    run_cmd(10'd30, 10'd40, 10'd31, 10'd40, 8'h3C, 2, 3);
    total++;
    if (we_l[2] !== 1'b1 || we_l[4] !== 1'b1 || xl[2] !== 10'd30 ||
        xl[3] !== 10'd30 || xl[4] !== 10'd30 || yl[4] !== 10'd40)
      $display("FAIL bp_hold: we2=%b we4=%b x=%0d,%0d,%0d want 1 1 30,30,30",
               we_l[2], we_l[4], xl[2], xl[3], xl[4]);
    else passed++;
    total++;
    if (nwr !== 2 || wx[0] !== 10'd30 || wx[1] !== 10'd31 ||
        wcyc[0] !== 5 || wcyc[1] !== 6)
      $display("FAIL bp_writes: n=%0d x=%0d@%0d,%0d@%0d want 2 30@5,31@6",
               nwr, wx[0], wcyc[0], wx[1], wcyc[1]);
    else passed++;
    total++;
    if (done_c !== 7)
      $display("FAIL bp_done: got cycle %0d want 7", done_c);
    else passed++;
  endtask

`ifdef RECT_FILL_CLIP_EN
  task automatic test_clip();
    run_cmd(10'd798, 10'd598, 10'd900, 10'd700, 8'h77, 0, 0);
    total++;
    if (nwr !== 4)
      $display("FAIL clip_count: got %0d want 4", nwr);
    else passed++;
    total++;
    if (wx[0] !== 10'd798 || wy[0] !== 10'd598 ||
        wx[1] !== 10'd799 || wy[1] !== 10'd598 ||
        wx[2] !== 10'd798 || wy[2] !== 10'd599 ||
        wx[3] !== 10'd799 || wy[3] !== 10'd599)
      $display("FAIL clip_order: last got (%0d,%0d) want (799,599)",
               wx[3], wy[3]);
    else passed++;
    total++;
    if (done_c !== 6)
      $display("FAIL clip_done: got cycle %0d want 6", done_c);
    else passed++;
    run_cmd(10'd800, 10'd0, 10'd810, 10'd5, 8'h01, 0, 0);
    total++;
    if (nwr !== 0 || done_c !== 2)
      $display("FAIL clip_offscreen: writes=%0d done=%0d want 0 2",
               nwr, done_c);
    else passed++;
  endtask
`else
  task automatic test_no_clip();
    run_cmd(10'd1023, 10'd5, 10'd1020, 10'd5, 8'h07, 0, 0);
    total++;
    if (nwr !== 4)
      $display("FAIL noclip_count: got %0d want 4", nwr);
    else passed++;
    total++;
    if (wx[0] !== 10'd1020 || wx[3] !== 10'd1023 || wy[3] !== 10'd5)
      $display("FAIL noclip_edge: first x=%0d last x=%0d want 1020 1023",
               wx[0], wx[3]);
    else passed++;
    total++;
    if (done_c !== 6)
      $display("FAIL noclip_done: got cycle %0d want 6", done_c);
    else passed++;
  endtask
`endif

  task automatic test_reset_mid_fill();
    int dn;
    int we;
    @(negedge PIXEL_CLK);
    CMD_X0 = 10'd0; CMD_Y0 = 10'd0;
    CMD_X1 = 10'd9; CMD_Y1 = 10'd9;
    CMD_COLOR = 8'hEE;
    CMD_VALID = 1'b1;
    @(posedge PIXEL_CLK);
    #1;
    CMD_VALID = 1'b0;
    repeat (3) begin
      @(posedge PIXEL_CLK);
      #1;
    end
    total++;
    if (PIX_WE !== 1'b1 || PIX_HORIZONTAL !== 10'd2)
      $display("FAIL rst_third_px: we=%b x=%0d want 1 2",
               PIX_WE, PIX_HORIZONTAL);
    else passed++;
    RST = 1'b1;
    #1;
    total++;
    if (PIX_WE !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0)
      $display("FAIL rst_abort: we=%b busy=%b done=%b want 0 0 0",
               PIX_WE, BUSY, DONE);
    else passed++;
    dn = 0;
    we = 0;
    repeat (2) begin
      @(posedge PIXEL_CLK);
      #1;
      if (DONE) dn++;
      if (PIX_WE) we++;
    end
    @(negedge PIXEL_CLK);
    RST = 1'b0;
    repeat (3) begin
      @(posedge PIXEL_CLK);
      #1;
      if (DONE) dn++;
      if (PIX_WE) we++;
    end
    total++;
    if (dn !== 0 || we !== 0)
      $display("FAIL rst_quiet: done=%0d we=%0d want 0 0", dn, we);
    else passed++;
    run_cmd(10'd3, 10'd3, 10'd3, 10'd3, 8'h11, 0, 0);
    total++;
    if (nwr !== 1 || wx[0] !== 10'd3 || wc[0] !== 8'h11 || done_c !== 3)
      $display("FAIL rst_next_cmd: n=%0d x=%0d c=%h done=%0d want 1 3 11 3",
               nwr, wx[0], wc[0], done_c);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int nw;
    int early_rdy;
    @(negedge PIXEL_CLK);
    CMD_X0 = 10'd0; CMD_Y0 = 10'd0;
    CMD_X1 = 10'd1; CMD_Y1 = 10'd0;
    CMD_COLOR = 8'h01;
    CMD_VALID = 1'b1;
    @(posedge PIXEL_CLK);
    #1;
    CMD_X0 = 10'd20; CMD_Y0 = 10'd20;
    CMD_X1 = 10'd20; CMD_Y1 = 10'd20;
    CMD_COLOR = 8'h02;
    for (int i = 0; i < 64; i++) begin
      we_l[i] = 1'b0; dn_l[i] = 1'b0; rd_l[i] = 1'b0;
      xl[i] = '0; yl[i] = '0; cl[i] = '0;
    end
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) begin
        @(posedge PIXEL_CLK);
        #1;
      end
      if (c == 6) CMD_VALID = 1'b0;
      we_l[c] = PIX_WE;
      dn_l[c] = DONE;
      rd_l[c] = CMD_READY;
      xl[c]   = PIX_HORIZONTAL;
      cl[c]   = PIX_COLOR;
    end
    CMD_VALID = 1'b0;
    nw = 0;
    early_rdy = 0;
    for (int c = 1; c <= 10; c++) if (we_l[c]) nw++;
    for (int c = 1; c <= 4; c++) if (rd_l[c]) early_rdy++;
    total++;
    if (early_rdy !== 0 || rd_l[5] !== 1'b1 || rd_l[6] !== 1'b0)
      $display("FAIL b2b_ready: early=%0d c5=%b c6=%b want 0 1 0",
               early_rdy, rd_l[5], rd_l[6]);
    else passed++;
    total++;
    if (we_l[2] !== 1'b1 || xl[2] !== 10'd0 || cl[2] !== 8'h01 ||
        we_l[3] !== 1'b1 || xl[3] !== 10'd1 || dn_l[4] !== 1'b1)
      $display("FAIL b2b_first: x=%0d,%0d c=%h done4=%b want 0,1 01 1",
               xl[2], xl[3], cl[2], dn_l[4]);
    else passed++;
    total++;
    if (we_l[7] !== 1'b1 || xl[7] !== 10'd20 || cl[7] !== 8'h02 ||
        dn_l[8] !== 1'b1)
      $display("FAIL b2b_second: we7=%b x=%0d c=%h done8=%b want 1 20 02 1",
               we_l[7], xl[7], cl[7], dn_l[8]);
    else passed++;
    total++;
    if (nw !== 3 || we_l[4] !== 1'b0 || we_l[5] !== 1'b0 ||
        we_l[6] !== 1'b0)
      $display("FAIL b2b_overlap: writes=%0d we4..6=%b%b%b want 3 000",
               nw, we_l[4], we_l[5], we_l[6]);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    RST = 1'b1;
    CMD_VALID = 1'b0;
    CMD_X0 = '0; CMD_Y0 = '0;
    CMD_X1 = '0; CMD_Y1 = '0;
    CMD_COLOR = '0;
    PIX_READY = 1'b1;
    test_reset();
    test_single_pixel();
    test_swapped();
    test_backpressure();
`ifdef RECT_FILL_CLIP_EN
    test_clip();
`else
    test_no_clip();
`endif
    test_reset_mid_fill();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
